// File: rtl/secded_decoder_pipe.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready flow control,
// detect-only mode, single-error position reporting and saturating error counters.
module secded_decoder_pipe #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned R      = (DATA_W == 4)  ? 3 :
                                     (DATA_W == 11) ? 4 :
                                     (DATA_W == 26) ? 5 :
                                     (DATA_W == 57) ? 6 : 3,
    localparam int unsigned CODE_W = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err_corr,
    output logic              err_uncorr,
    output logic [R-1:0]      err_pos,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    if (!(DATA_W == 4 || DATA_W == 11 || DATA_W == 26 || DATA_W == 57)) begin : g_bad_width
        $error("secded_decoder_pipe: DATA_W must be 4, 11, 26 or 57");
    end

    // Bit k of the syndrome covers every Hamming position with bit k set.
    function automatic logic [CODE_W-2:0] syn_mask(input int unsigned k);
        logic [CODE_W-2:0] m;
        m = '0;
        for (int unsigned i = 0; i < CODE_W - 1; i++) begin
            m[i] = (((i + 32'd1) >> k) & 32'd1) != 32'd0;
        end
        return m;
    endfunction

    // in_code index holding data bit j (j-th non-power-of-two position).
    function automatic int unsigned data_idx(input int unsigned j);
        int unsigned cnt;
        int unsigned res;
        cnt = 0;
        res = 0;
        for (int unsigned p = 1; p < CODE_W; p++) begin
            if ((p & (p - 32'd1)) != 32'd0) begin
                if (cnt == j) res = p - 32'd1;
                cnt++;
            end
        end
        return res;
    endfunction

    logic [R-1:0]      syn_c;
    logic [DATA_W-1:0] raw_c;
    logic [DATA_W-1:0] dec_c;
    logic              flip_c;
    logic              s1_adv_c;
    logic              s2_adv_c;
    logic              out_fire_c;

    logic              s1_valid_q, s1_valid_d;
    logic [R-1:0]      s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_cen_q, s1_cen_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              err_corr_q, err_corr_d;
    logic              err_uncorr_q, err_uncorr_d;
    logic [R-1:0]      err_pos_q, err_pos_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    for (genvar k = 0; k < R; k++) begin : g_syn
        assign syn_c[k] = ^(in_code[CODE_W-2:0] & syn_mask(k));
    end

    // Stage 1 keeps only the data bits; the parity bits are fully summarised by S and P.
    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        assign raw_c[j] = in_code[data_idx(j)];
        assign dec_c[j] = s1_data_q[j] ^ (flip_c & (s1_syn_q == R'(data_idx(j) + 1)));
    end

    assign flip_c     = s1_par_q & (s1_syn_q != '0) & s1_cen_q;
    assign s2_adv_c   = ~out_valid_q | out_ready;
    assign s1_adv_c   = ~s1_valid_q | s2_adv_c;
    assign out_fire_c = out_valid_q & out_ready;
    assign in_ready   = s1_adv_c;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_syn_d     = s1_syn_q;
        s1_par_d     = s1_par_q;
        s1_data_d    = s1_data_q;
        s1_cen_d     = s1_cen_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        err_corr_d   = err_corr_q;
        err_uncorr_d = err_uncorr_q;
        err_pos_d    = err_pos_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;

        if (s1_adv_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_syn_d  = syn_c;
                s1_par_d  = ^in_code;
                s1_data_d = raw_c;
                s1_cen_d  = correct_en;
            end
        end

        if (s2_adv_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d   = dec_c;
                err_corr_d   = s1_par_q;
                err_uncorr_d = ~s1_par_q & (s1_syn_q != '0);
                err_pos_d    = s1_par_q ? s1_syn_q : '0;
            end
        end

        // Clear wins over a same-cycle delivery.
        if (clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_fire_c) begin
            if (err_corr_q && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + CNT_W'(1);
            if (err_uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q   <= 1'b0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s1_data_q    <= '0;
            s1_cen_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
            err_pos_q    <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s1_data_q    <= s1_data_d;
            s1_cen_q     <= s1_cen_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            err_corr_q   <= err_corr_d;
            err_uncorr_q <= err_uncorr_d;
            err_pos_q    <= err_pos_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign err_corr   = err_corr_q;
    assign err_uncorr = err_uncorr_q;
    assign err_pos    = err_pos_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Bench for secded_decoder_pipe: an (8,4) instance with 2-bit counters and a (16,11) instance,
// checked against a position-XOR Hamming model.
module tb_secded_decoder_pipe;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_cen, a_out_valid, a_out_ready;
    logic [7:0] a_in_code;
    logic [3:0] a_out_data;
    logic       a_ec, a_eu, a_clr;
    logic [2:0] a_pos;
    logic [1:0] a_cc, a_uc;

    logic        b_in_valid, b_in_ready, b_cen, b_out_valid, b_out_ready;
    logic [15:0] b_in_code;
    logic [10:0] b_out_data;
    logic        b_ec, b_eu, b_clr;
    logic [3:0]  b_pos;
    logic [15:0] b_cc, b_uc;

    int pass_cnt = 0;
    int total_cnt = 0;

    secded_decoder_pipe #(.DATA_W(4), .CNT_W(2)) dut_a (
        .clk(clk), .rstn(rstn), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_code(a_in_code), .correct_en(a_cen), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .err_corr(a_ec),
        .err_uncorr(a_eu), .err_pos(a_pos), .clr_cnt(a_clr),
        .corr_cnt(a_cc), .uncorr_cnt(a_uc)
    );

    secded_decoder_pipe #(.DATA_W(11), .CNT_W(16)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_code(b_in_code), .correct_en(b_cen), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .err_corr(b_ec),
        .err_uncorr(b_eu), .err_pos(b_pos), .clr_cnt(b_clr),
        .corr_cnt(b_cc), .uncorr_cnt(b_uc)
    );

    // Encoder: place data at non-power-of-two positions, then set parity bits so that
    // the XOR of all set positions is zero, then even overall parity.
    function automatic logic [63:0] enc(input logic [63:0] data, input int dw, input int r);
        logic [63:0] c;
        int j, s, cw;
        c = '0; j = 0; s = 0; cw = dw + r + 1;
        for (int p = 1; p < cw; p++) if ((p & (p - 1)) != 0) begin c[p-1] = data[j]; j++; end
        for (int p = 1; p < cw; p++) if (c[p-1]) s = s ^ p;
        for (int k = 0; k < r; k++) if (((s >> k) & 1) != 0) c[(1 << k) - 1] = 1'b1;
        c[cw-1] = ^c;
        return c;
    endfunction

    // Reference decoder: syndrome as XOR of positions of all set bits.
    function automatic void mdec(input logic [63:0] code, input int dw, input int r, input bit cen,
                                 output logic [63:0] data, output logic ec, output logic eu,
                                 output int pos);
        int cw, s, j;
        logic p;
        logic [63:0] f;
        cw = dw + r + 1; s = 0; p = 1'b0; j = 0;
        for (int i = 0; i < cw; i++) if (code[i]) begin p = ~p; if (i < cw - 1) s = s ^ (i + 1); end
        ec = p;
        eu = !p && (s != 0);
        pos = p ? s : 0;
        f = code;
        if (p && s != 0 && cen) f[s-1] = ~f[s-1];
        data = '0;
        for (int q = 1; q < cw; q++) if ((q & (q - 1)) != 0) begin data[j] = f[q-1]; j++; end
    endfunction

    task automatic a_xfer(input logic [7:0] code, input bit cen, output logic [3:0] d,
                          output logic ec, output logic eu, output logic [2:0] pos);
        bit got;
        got = 1'b0;
        d = '0; ec = 1'b0; eu = 1'b0; pos = '0;
        a_in_code = code; a_cen = cen; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            if (a_out_valid) begin
                got = 1'b1; d = a_out_data; ec = a_ec; eu = a_eu; pos = a_pos;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL a_timeout: code=%h out_valid never rose", code);
        end
    endtask

    task automatic b_xfer(input logic [15:0] code, output logic [10:0] d,
                          output logic ec, output logic eu, output logic [3:0] pos);
        bit got;
        got = 1'b0;
        d = '0; ec = 1'b0; eu = 1'b0; pos = '0;
        b_in_code = code; b_cen = 1'b1; b_in_valid = 1'b1; b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            if (b_out_valid) begin
                got = 1'b1; d = b_out_data; ec = b_ec; eu = b_eu; pos = b_pos;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL b_timeout: code=%h out_valid never rose", code);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        a_in_valid = 0; a_in_code = '0; a_cen = 1; a_out_ready = 1; a_clr = 0;
        b_in_valid = 0; b_in_code = '0; b_cen = 1; b_out_ready = 1; b_clr = 0;
        #23 rstn = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({a_out_valid, a_out_data, a_ec, a_eu, a_pos, a_cc, a_uc} !== 15'd0)
            $display("FAIL reset_outputs: got %b want all zero",
                     {a_out_valid, a_out_data, a_ec, a_eu, a_pos, a_cc, a_uc});
        else pass_cnt++;
        total_cnt++;
        if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        a_in_code = 8'h55; a_cen = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        total_cnt++;
        if (a_out_valid !== 1'b0) $display("FAIL latency_early: out_valid=%b want 0", a_out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({a_out_valid, a_out_data, a_ec, a_eu, a_pos} !== {1'b1, 4'hB, 1'b0, 1'b0, 3'd0})
            $display("FAIL clean_55: got v=%b d=%h c=%b u=%b p=%0d want v=1 d=b c=0 u=0 p=0",
                     a_out_valid, a_out_data, a_ec, a_eu, a_pos);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        logic [3:0] d; logic ec, eu; logic [2:0] pos;
        a_xfer(8'h45, 1'b1, d, ec, eu, pos);
        total_cnt++;
        if ({d, ec, eu, pos} !== {4'hB, 1'b1, 1'b0, 3'd5})
            $display("FAIL single_corr: got d=%h c=%b u=%b p=%0d want d=b c=1 u=0 p=5", d, ec, eu, pos);
        else pass_cnt++;
        total_cnt++;
        if (a_cc !== 2'd1) $display("FAIL corr_cnt_1: got %0d want 1", a_cc);
        else pass_cnt++;
        a_xfer(8'h45, 1'b0, d, ec, eu, pos);
        total_cnt++;
        if ({d, ec, eu, pos} !== {4'h9, 1'b1, 1'b0, 3'd5})
            $display("FAIL detect_only: got d=%h c=%b u=%b p=%0d want d=9 c=1 u=0 p=5", d, ec, eu, pos);
        else pass_cnt++;
    endtask

    task automatic test_parity_and_double;
        logic [3:0] d; logic ec, eu; logic [2:0] pos;
        a_xfer(8'hD5, 1'b1, d, ec, eu, pos);
        total_cnt++;
        if ({d, ec, eu, pos} !== {4'hB, 1'b1, 1'b0, 3'd0})
            $display("FAIL overall_parity: got d=%h c=%b u=%b p=%0d want d=b c=1 u=0 p=0", d, ec, eu, pos);
        else pass_cnt++;
        a_xfer(8'h56, 1'b1, d, ec, eu, pos);
        total_cnt++;
        if ({d, ec, eu, pos} !== {4'hB, 1'b0, 1'b1, 3'd0})
            $display("FAIL double_err: got d=%h c=%b u=%b p=%0d want d=b c=0 u=1 p=0", d, ec, eu, pos);
        else pass_cnt++;
        total_cnt++;
        if (a_uc !== 2'd1) $display("FAIL uncorr_cnt_1: got %0d want 1", a_uc);
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [3:0] d; logic ec, eu; logic [2:0] pos;
        logic [63:0] code, md; logic mec, meu; int mpos;
        int mcc, muc, b1, b2, nerr;
        bit cen;
        a_clr = 1'b1; @(posedge clk); #1; a_clr = 1'b0;
        mcc = 0; muc = 0;
        for (int t = 0; t < 40; t++) begin
            code = enc(64'($urandom_range(0, 15)), 4, 3);
            nerr = $urandom_range(0, 2);
            b1 = $urandom_range(0, 7);
            b2 = (b1 + $urandom_range(1, 7)) % 8;
            if (nerr >= 1) code[b1] = ~code[b1];
            if (nerr == 2) code[b2] = ~code[b2];
            cen = 1'($urandom_range(0, 1));
            mdec(code, 4, 3, cen, md, mec, meu, mpos);
            if (mec && mcc < 3) mcc++;
            if (meu && muc < 3) muc++;
            a_xfer(code[7:0], cen, d, ec, eu, pos);
            total_cnt++;
            if ({d, ec, eu, pos} !== {md[3:0], mec, meu, 3'(mpos)})
                $display("FAIL random_word: code=%h cen=%b got d=%h c=%b u=%b p=%0d want d=%h c=%b u=%b p=%0d",
                         code[7:0], cen, d, ec, eu, pos, md[3:0], mec, meu, mpos);
            else pass_cnt++;
            total_cnt++;
            if ({a_cc, a_uc} !== {2'(mcc), 2'(muc)})
                $display("FAIL random_counters: got c=%0d u=%0d want c=%0d u=%0d", a_cc, a_uc, mcc, muc);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] codes[10];
        logic [8:0] exp_q[$];
        logic [63:0] md; logic mec, meu; int mpos;
        logic [8:0] held;
        bit stall;
        int sent, rcvd, occ, b;
        for (int i = 0; i < 10; i++) begin
            codes[i] = enc(64'($urandom_range(0, 15)), 4, 3)[7:0];
            b = $urandom_range(0, 8);
            if (b < 8) codes[i][b] = ~codes[i][b];
        end
        sent = 0; rcvd = 0; occ = 0; stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 80 && rcvd < 10; cyc++) begin
            if (stall) begin
                total_cnt++;
                if ({a_out_valid, a_out_data, a_ec, a_eu, a_pos} !== {1'b1, held})
                    $display("FAIL stall_hold: got v=%b %h want v=1 %h", a_out_valid,
                             {a_out_data, a_ec, a_eu, a_pos}, held);
                else pass_cnt++;
            end
            a_out_ready = (cyc % 2 == 0);
            a_in_valid = (sent < 10);
            a_in_code = codes[sent < 10 ? sent : 9];
            a_cen = 1'b1;
            #1;
            total_cnt++;
            if (a_in_ready !== !(occ == 2 && !a_out_ready))
                $display("FAIL b2b_in_ready: cyc=%0d got %b want %b occ=%0d", cyc, a_in_ready,
                         !(occ == 2 && !a_out_ready), occ);
            else pass_cnt++;
            if (a_out_valid && a_out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0)
                    $display("FAIL b2b_extra: unexpected word %h", {a_out_data, a_ec, a_eu, a_pos});
                else if ({a_out_data, a_ec, a_eu, a_pos} !== exp_q[0])
                    $display("FAIL b2b_data: word %0d got %h want %h", rcvd,
                             {a_out_data, a_ec, a_eu, a_pos}, exp_q[0]);
                else pass_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                rcvd++; occ--;
            end
            if (a_in_valid && a_in_ready) begin
                mdec(64'(codes[sent]), 4, 3, 1'b1, md, mec, meu, mpos);
                exp_q.push_back({md[3:0], mec, meu, 3'(mpos)});
                sent++; occ++;
            end
            stall = a_out_valid && !a_out_ready;
            held = {a_out_data, a_ec, a_eu, a_pos};
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        total_cnt++;
        if (rcvd != 10) $display("FAIL b2b_count: got %0d words want 10", rcvd);
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        logic [3:0] d; logic ec, eu; logic [2:0] pos;
        logic [63:0] code;
        bit got;
        a_clr = 1'b1; @(posedge clk); #1; a_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            code = enc(64'($urandom_range(0, 15)), 4, 3);
            code[i] = ~code[i];
            a_xfer(code[7:0], 1'b1, d, ec, eu, pos);
            total_cnt++;
            if (a_cc !== 2'((i + 1 > 3) ? 3 : i + 1))
                $display("FAIL sat_count: after %0d got %0d want %0d", i + 1, a_cc, (i + 1 > 3) ? 3 : i + 1);
            else pass_cnt++;
        end
        a_in_code = 8'h45; a_cen = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            if (a_out_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        total_cnt++;
        if (!got || a_cc !== 2'd0) $display("FAIL clr_priority: seen=%b got %0d want 0", got, a_cc);
        else pass_cnt++;
    endtask

    task automatic test_reset_inflight;
        logic [3:0] d; logic ec, eu; logic [2:0] pos;
        a_xfer(8'h45, 1'b1, d, ec, eu, pos);
        a_xfer(8'h56, 1'b1, d, ec, eu, pos);
        a_out_ready = 1'b0; a_cen = 1'b1; a_in_valid = 1'b1;
        a_in_code = 8'h45; @(posedge clk); #1;
        a_in_code = 8'hD5; @(posedge clk); #1;
        a_in_valid = 1'b0;
        total_cnt++;
        if ({a_out_valid, a_cc, a_uc} !== {1'b1, 2'd1, 2'd1})
            $display("FAIL pre_reset: got v=%b c=%0d u=%0d want v=1 c=1 u=1", a_out_valid, a_cc, a_uc);
        else pass_cnt++;
        #2 rstn = 1'b0;
        #1;
        total_cnt++;
        if ({a_out_valid, a_out_data, a_ec, a_eu, a_pos, a_cc, a_uc} !== 15'd0)
            $display("FAIL async_reset: got %b want all zero",
                     {a_out_valid, a_out_data, a_ec, a_eu, a_pos, a_cc, a_uc});
        else pass_cnt++;
        @(posedge clk); #3 rstn = 1'b1;
        a_out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (a_out_valid !== 1'b0) $display("FAIL stale_word: cycle %0d out_valid=%b want 0", n, a_out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_sweep11;
        logic [10:0] d; logic ec, eu; logic [3:0] pos;
        logic [63:0] code, data;
        logic [15:0] c;
        for (int t = 0; t < 4; t++) begin
            data = 64'($urandom_range(0, 2047));
            code = enc(data, 11, 4);
            b_xfer(code[15:0], d, ec, eu, pos);
            total_cnt++;
            if ({d, ec, eu, pos} !== {data[10:0], 1'b0, 1'b0, 4'd0})
                $display("FAIL w11_clean: got d=%h c=%b u=%b p=%0d want d=%h clean", d, ec, eu, pos, data[10:0]);
            else pass_cnt++;
            for (int i = 0; i < 16; i++) begin
                c = code[15:0];
                c[i] = ~c[i];
                b_xfer(c, d, ec, eu, pos);
                total_cnt++;
                if ({d, ec, eu, pos} !== {data[10:0], 1'b1, 1'b0, 4'((i < 15) ? i + 1 : 0)})
                    $display("FAIL w11_flip: bit %0d got d=%h c=%b u=%b p=%0d want d=%h c=1 u=0 p=%0d",
                             i, d, ec, eu, pos, data[10:0], (i < 15) ? i + 1 : 0);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (b_cc !== 16'd64) $display("FAIL w11_corr_cnt: got %0d want 64", b_cc);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_parity_and_double();
        test_random();
        test_back_to_back();
        test_saturation();
        test_reset_inflight();
        test_sweep11();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/secded_decoder_pipe.md
Name: secded_decoder_pipe

Overview:
Parametrised, pipelined single-error-correct / double-error-detect (SECDED) Hamming decoder with valid/ready streaming.
- Generalises the fixed 4-bit (8,4) decoder to any perfect-Hamming data width.
- Adds backpressure, a detect-only mode, error position reporting and saturating error statistics counters.
- Sits between the memory/link read path and consumers of the protected data.

Parameters:
- DATA_W, 4, payload width. Legal values: 4, 11, 26, 57. Other values are a elaboration-time error.
- R, derived (3/4/5/6 for the legal DATA_W), number of Hamming parity bits. Localparam, not overridable.
- CODE_W, derived = DATA_W+R+1, codeword width including overall parity.
- CNT_W, 16, width of each error statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept a codeword this cycle.
- in_code  in  CODE_W  codeword.
- correct_en  in  1  1 = correct single errors; 0 = detect-only. Sampled with in_code.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  decoded data.
- err_corr  out  1  single-bit error detected.
- err_uncorr  out  1  double-bit error detected.
- err_pos  out  R  Hamming position (1..CODE_W-1) of the single error; 0 if none or if the error is in the overall parity bit.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of err_corr results delivered.
- uncorr_cnt  out  CNT_W  count of err_uncorr results delivered.

Behaviour:
- Bit map: in_code[i], for i < CODE_W-1, is Hamming position i+1. Positions that are powers of two are parity bits. Data bit j occupies the j-th non-power-of-two position in ascending order. in_code[CODE_W-1] is overall parity (even over all CODE_W bits).
- Stage 1 registers:
  - Syndrome S (R bits). Bit k = XOR of all positions with bit k set.
  - Overall parity P = XOR of all CODE_W bits.
  - Raw codeword and correct_en.
- Stage 2 registers out_data, err_corr, err_uncorr and err_pos.
- Latency: exactly 2 cycles from input handshake to out_valid when out_ready is held 1. Throughput is 1 word/cycle.
- Decode rules:
  - P=0, S=0: no error. Flags 0, err_pos=0.
  - P=1: err_corr=1, err_pos=S.
    - S≠0: the bit at position S is flipped before data extraction, but only if correct_en=1.
    - S=0: the error is in the overall parity bit. Data is unaffected.
  - P=0, S≠0: err_uncorr=1, err_pos=0. out_data is the raw, uncorrected data.
  - With correct_en=0, flags and err_pos are computed identically, but out_data is always the raw data.
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - Stage 2 advances when ~out_valid | out_ready.
  - Stage 1 advances when ~s1_valid | stage-2 advance.
  - in_ready = stage-1 advance. This is combinational from out_ready; no combinational in_valid→out_valid path.
  - While stalled, out_* and the stage-1 contents hold stable. No word is dropped or duplicated.
- Counters:
  - On each output transfer, the matching counter increments by 1 and saturates at 2^CNT_W-1.
  - clr_cnt=1 sets both counters to 0 next cycle. It has priority over a simultaneous increment.
- Reset (asynchronous, any time):
  - out_valid=0, s1_valid=0, out_data=0, err_corr=0, err_uncorr=0, err_pos=0, corr_cnt=0, uncorr_cnt=0.
  - in_ready=1 once released.
  - In-flight words are discarded.

Test Plan:
- DATA_W=4, correct_en=1, in_code=8'h55, out_ready=1 → 2 cycles later: out_data=4'hB, err_corr=0, err_uncorr=0, err_pos=0.
- in_code=8'h45 (D2 flipped) → out_data=4'hB, err_corr=1, err_pos=5, corr_cnt=1. Same word with correct_en=0 → out_data=4'h9, err_corr=1, err_pos=5.
- in_code=8'hD5 (overall parity flipped) → out_data=4'hB, err_corr=1, err_pos=0. in_code=8'h56 (P1 and P2 flipped) → err_uncorr=1, out_data=4'hB raw, err_pos=0, uncorr_cnt=1.
- Stream 10 back-to-back words while toggling out_ready 1/0 every cycle → all 10 outputs appear in order with correct data. Outputs are stable while out_ready=0. in_ready=0 exactly when both stages are full and out_ready=0.
- CNT_W=2: deliver 5 single-error words → corr_cnt stops at 3. Assert clr_cnt on the same cycle as a 6th delivery → corr_cnt=0.
- Assert rstn low with 2 words in flight → out_valid=0 and all outputs/counters are 0 immediately. After release, no stale word ever appears. Repeat the first scenario with DATA_W=11 and an exhaustive single-bit flip sweep → every flip corrected, err_pos = flipped position.
